// File: rtl/freq_gate_disp.sv
// ---------------------------------------------------------------------------
// freq_gate_disp
//
// Gate-time controller and two-digit seven-segment display driver for a
// simple frequency counter. A fixed-length gate window enables an external
// 2-digit BCD counter. At the end of each window the BCD result and an
// overflow flag are latched and shown on a multiplexed two-digit display.
//
// Measurement cycle (repeats forever, never stalls):
//   CLEAR (1) -> GATE (GATE_CYCLES) -> HOLD (2) -> LATCH (1) -> CLEAR ...
//
// Parameters
//   GATE_CYCLES  gate-open length in clk cycles (4 .. 2^20)
//   SCAN_DIV     clk cycles each display digit is driven (2 .. 2^16)
//
// Ports
//   clk        in   reference clock, rising edge
//   clr        in   asynchronous active-high reset
//   high       in   BCD tens digit from the upstream counter
//   low        in   BCD units digit from the upstream counter
//   cn         in   carry from the upstream counter (asynchronous to clk)
//   gate       out  count-enable window, high only in GATE
//   cnt_clr    out  counter clear, high only in CLEAR
//   disp_high  out  latched tens digit
//   disp_low   out  latched units digit
//   ovf        out  latched overflow for the last gate
//   valid      out  one-cycle pulse on the cycle after LATCH
//   seg        out  segment drive, active-high, {g,f,e,d,c,b,a}
//   dig_sel    out  one-hot digit enable, bit1 tens, bit0 units
//
// Build option
//   FREQ_GATE_DISP_LZB_EN  when defined, a tens digit of 0 is blanked
//                          (unless overflow is showing).
// ---------------------------------------------------------------------------
module freq_gate_disp #(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned SCAN_DIV    = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] high,
    input  logic [3:0] low,
    input  logic       cn,
    output logic       gate,
    output logic       cnt_clr,
    output logic [3:0] disp_high,
    output logic [3:0] disp_low,
    output logic       ovf,
    output logic       valid,
    output logic [6:0] seg,
    output logic [1:0] dig_sel
);

    localparam int unsigned GW = $clog2(GATE_CYCLES);
    localparam int unsigned SW = $clog2(SCAN_DIV);

    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0] GATE_ONE  = GW'(1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SCAN_ONE  = SW'(1);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_GATE  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_run;
    logic [GW-1:0] r_gate_cnt;
    logic          r_hold_cnt;
    logic          w_gate_tc;

    logic          r_cn_meta;
    logic          r_cn_sync;
    logic          r_sticky;

    logic [3:0]    r_disp_high;
    logic [3:0]    r_disp_low;
    logic          r_ovf;
    logic          r_valid;

    logic [SW-1:0] r_scan_cnt;
    logic [1:0]    r_dig_sel;

    logic [3:0]    w_digit;
    logic [6:0]    w_seg;

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------

    // Exit from GATE is an equality on the terminal count of a counter that
    // only ever steps by one, so it cannot be jumped over.
    assign w_gate_tc = (r_gate_cnt == GATE_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // r_run is low only on the first edge after reset release, which
            // turns that edge into the start of a full 1-cycle CLEAR.
            S_CLEAR: if (r_run)      w_state_nxt = S_GATE;
            S_GATE:  if (w_gate_tc)  w_state_nxt = S_HOLD;
            S_HOLD:  if (r_hold_cnt) w_state_nxt = S_LATCH;
            S_LATCH:                 w_state_nxt = S_CLEAR;
            default:                 w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_CLEAR;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    // Gate-length counter: 0..GATE_CYCLES-1 while in GATE, parked at 0 else.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_gate_cnt <= '0;
        end else if (r_state == S_GATE) begin
            if (w_gate_tc) begin
                r_gate_cnt <= '0;
            end else begin
                r_gate_cnt <= r_gate_cnt + GATE_ONE;
            end
        end else begin
            r_gate_cnt <= '0;
        end
    end

    // Two-cycle settle counter for HOLD.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hold_cnt <= 1'b0;
        end else if (r_state == S_HOLD) begin
            r_hold_cnt <= ~r_hold_cnt;
        end else begin
            r_hold_cnt <= 1'b0;
        end
    end

    assign gate    = (r_state == S_GATE);
    assign cnt_clr = (r_state == S_CLEAR);

    // ------------------------------------------------------------------
    // Carry synchronizer and overflow sticky bit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cn_meta <= 1'b0;
            r_cn_sync <= 1'b0;
        end else begin
            r_cn_meta <= cn;
            r_cn_sync <= r_cn_meta;
        end
    end

    // CLEAR wins over a carry arriving in the same cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sticky <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_sticky <= 1'b0;
        end else if ((r_state == S_GATE || r_state == S_HOLD) && r_cn_sync) begin
            r_sticky <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result latch and valid strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_disp_high <= 4'd0;
            r_disp_low  <= 4'd0;
            r_ovf       <= 1'b0;
        end else if (r_state == S_LATCH) begin
            r_disp_high <= high;
            r_disp_low  <= low;
            r_ovf       <= r_sticky;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= (r_state == S_LATCH);
        end
    end

    assign disp_high = r_disp_high;
    assign disp_low  = r_disp_low;
    assign ovf       = r_ovf;
    assign valid     = r_valid;

    // ------------------------------------------------------------------
    // Display scan: free-running, independent of the measurement FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_scan_cnt <= '0;
            r_dig_sel  <= 2'b01;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_dig_sel  <= {r_dig_sel[0], r_dig_sel[1]};
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_ONE;
        end
    end

    assign dig_sel = r_dig_sel;

    // ------------------------------------------------------------------
    // Segment decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_bcd_to_seg(input logic [3:0] i_val);
        logic [6:0] w_res;
        case (i_val)
            4'd0:    w_res = 7'h3F;
            4'd1:    w_res = 7'h06;
            4'd2:    w_res = 7'h5B;
            4'd3:    w_res = 7'h4F;
            4'd4:    w_res = 7'h66;
            4'd5:    w_res = 7'h6D;
            4'd6:    w_res = 7'h7D;
            4'd7:    w_res = 7'h07;
            4'd8:    w_res = 7'h7F;
            4'd9:    w_res = 7'h6F;
            default: w_res = 7'h00;  // non-BCD codes show blank
        endcase
        return w_res;
    endfunction

    always_comb begin
        w_digit = r_dig_sel[1] ? r_disp_high : r_disp_low;
        w_seg   = f_bcd_to_seg(w_digit);
`ifdef FREQ_GATE_DISP_LZB_EN
        if (r_dig_sel[1] && (r_disp_high == 4'd0)) begin
            w_seg = 7'h00;
        end
`endif
        // Overflow shows "--" on both digits, overriding everything else.
        if (r_ovf) begin
            w_seg = 7'h40;
        end
    end

    assign seg = w_seg;

endmodule

// File: tb/tb_freq_gate_disp.sv
// ---------------------------------------------------------------------------
// tb_freq_gate_disp
//
// Self-checking bench for freq_gate_disp with GATE_CYCLES=10, SCAN_DIV=4.
// Expected behaviour comes from a period/phase model: the cycle count since
// reset release determines the phase within a GATE_CYCLES+4 period, and a
// carry counts toward overflow when its synchronized copy lands in GATE/HOLD.
// ---------------------------------------------------------------------------
module tb_freq_gate_disp;

    localparam int unsigned G  = 10;
    localparam int unsigned SD = 4;
    localparam int unsigned P  = G + 4;

`ifdef FREQ_GATE_DISP_LZB_EN
    localparam logic [6:0] TENS_ZERO = 7'h00;
`else
    localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] high = 4'd0;
    logic [3:0] low = 4'd0;
    logic       cn = 1'b0;
    logic       gate;
    logic       cnt_clr;
    logic [3:0] disp_high;
    logic [3:0] disp_low;
    logic       ovf;
    logic       valid;
    logic [6:0] seg;
    logic [1:0] dig_sel;

    freq_gate_disp #(
        .GATE_CYCLES(G),
        .SCAN_DIV   (SD)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .high     (high),
        .low      (low),
        .cn       (cn),
        .gate     (gate),
        .cnt_clr  (cnt_clr),
        .disp_high(disp_high),
        .disp_low (disp_low),
        .ovf      (ovf),
        .valid    (valid),
        .seg      (seg),
        .dig_sel  (dig_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned m_k = 0;       // rising edges since reset release
    logic        m_acc = 1'b0;  // overflow seen in the current window
    logic        m_prev_cn = 1'b0;
    logic [3:0]  m_high = 4'd0;
    logic [3:0]  m_low = 4'd0;
    logic        m_ovf = 1'b0;
    logic        m_valid = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        return tbl[v];
    endfunction

    function automatic int unsigned m_phase();
        if (m_k == 0) return 0;
        return (m_k - 1) % P;
    endfunction

    function automatic logic [1:0] m_dig();
        return (((m_k / SD) % 2) == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_edge();
        int unsigned ph;
        if (clr) begin
            m_k = 0; m_acc = 1'b0; m_prev_cn = 1'b0;
            m_high = 4'd0; m_low = 4'd0; m_ovf = 1'b0; m_valid = 1'b0;
            return;
        end
        m_k++;
        ph = (m_k - 1) % P;
        // carry sampled last edge is seen by the FSM in this new phase
        if (m_k >= 2 && ph >= 1 && ph <= G + 2 && m_prev_cn) m_acc = 1'b1;
        m_valid = 1'b0;
        if (ph == 0 && m_k > 1) begin
            m_high  = high;
            m_low   = low;
            m_ovf   = m_acc;
            m_valid = 1'b1;
        end
        if (ph == 0) m_acc = 1'b0;
        m_prev_cn = cn;
    endtask

    task automatic check_all();
        int unsigned ph;
        logic [1:0]  e_dig;
        logic [3:0]  sel;
        logic [6:0]  e_seg;
        ph    = m_phase();
        e_dig = m_dig();
        sel   = e_dig[1] ? m_high : m_low;
        e_seg = seg_of(sel);
`ifdef FREQ_GATE_DISP_LZB_EN
        if (e_dig[1] && m_high == 4'd0) e_seg = 7'h00;
`endif
        if (m_ovf) e_seg = 7'h40;
        chk("gate", gate, (m_k > 0 && ph >= 1 && ph <= G));
        chk("cnt_clr", cnt_clr, (ph == 0));
        chk("valid", valid, m_valid);
        chk("disp_high", disp_high, m_high);
        chk("disp_low", disp_low, m_low);
        chk("ovf", ovf, m_ovf);
        chk("dig_sel", dig_sel, e_dig);
        chk("seg", seg, e_seg);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_valid && n < 2 * P);
        if (!m_valid) chk(name, 32'd0, 32'd1);
    endtask

    task automatic wait_dig(input logic [1:0] target, input string name);
        int n = 0;
        while (m_dig() != target && n < 2 * SD) begin
            step();
            n++;
        end
        if (m_dig() != target) chk(name, 32'd0, 32'd1);
    endtask

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       pulse;
        logic [3:0] e_hi;
        logic [3:0] e_lo;
        logic       e_ovf;
        logic [6:0] e_tens;
        logic [6:0] e_units;
    } vec_t;

    vec_t vecs [6];

    logic rec_g [3*P+1];
    logic rec_c [3*P+1];
    logic rec_v [3*P+1];

    initial begin
        int n;
        int first_gate;
        int gate_len;
        int n_clr;
        int v1;
        int v2;
        int v_early;

        vecs[0] = '{hi: 4'd4, lo: 4'd7, pulse: 1'b0, e_hi: 4'd4, e_lo: 4'd7, e_ovf: 1'b0,
                    e_tens: 7'h66, e_units: 7'h07};
        vecs[1] = '{hi: 4'd0, lo: 4'd5, pulse: 1'b0, e_hi: 4'd0, e_lo: 4'd5, e_ovf: 1'b0,
                    e_tens: TENS_ZERO, e_units: 7'h6D};
        vecs[2] = '{hi: 4'd3, lo: 4'd2, pulse: 1'b1, e_hi: 4'd3, e_lo: 4'd2, e_ovf: 1'b1,
                    e_tens: 7'h40, e_units: 7'h40};
        vecs[3] = '{hi: 4'd9, lo: 4'd8, pulse: 1'b0, e_hi: 4'd9, e_lo: 4'd8, e_ovf: 1'b0,
                    e_tens: 7'h6F, e_units: 7'h7F};
        vecs[4] = '{hi: 4'hA, lo: 4'd1, pulse: 1'b0, e_hi: 4'hA, e_lo: 4'd1, e_ovf: 1'b0,
                    e_tens: 7'h00, e_units: 7'h06};
        vecs[5] = '{hi: 4'd6, lo: 4'hF, pulse: 1'b0, e_hi: 4'd6, e_lo: 4'hF, e_ovf: 1'b0,
                    e_tens: 7'h7D, e_units: 7'h00};

        // Reset
        #1 clr = 1'b1;
        #1;
        chk("rst_gate", gate, 1'b0);
        chk("rst_cnt_clr", cnt_clr, 1'b1);
        chk("rst_dig_sel", dig_sel, 2'b01);
        chk("rst_valid", valid, 1'b0);
        step();
        step();
        clr = 1'b0;

        // Table-driven measurements
        for (int i = 0; i < 6; i++) begin
            high = vecs[i].hi;
            low  = vecs[i].lo;
            if (vecs[i].pulse) begin
                n = 0;
                while (m_phase() != 5 && n < 2 * P) begin
                    step();
                    n++;
                end
                cn = 1'b1;
                step();
                cn = 1'b0;
            end
            wait_valid("vec_valid_timeout");
            chk("vec_disp_high", disp_high, vecs[i].e_hi);
            chk("vec_disp_low", disp_low, vecs[i].e_lo);
            chk("vec_ovf", ovf, vecs[i].e_ovf);
            wait_dig(2'b10, "vec_tens_timeout");
            chk("vec_seg_tens", seg, vecs[i].e_tens);
            wait_dig(2'b01, "vec_units_timeout");
            chk("vec_seg_units", seg, vecs[i].e_units);
        end

        // Abort in the middle of GATE
        n = 0;
        while (m_phase() != 5 && n < 2 * P) begin
            step();
            n++;
        end
        clr = 1'b1;
        #1;
        chk("abort_gate", gate, 1'b0);
        chk("abort_disp_high", disp_high, 4'd0);
        chk("abort_disp_low", disp_low, 4'd0);
        chk("abort_ovf", ovf, 1'b0);
        chk("abort_valid", valid, 1'b0);
        chk("abort_cnt_clr", cnt_clr, 1'b1);
        step();
        step();
        high = 4'd2;
        low  = 4'd1;
        clr  = 1'b0;

        // Timing of the period after release
        for (int c = 1; c <= 3 * P; c++) begin
            step();
            rec_g[c] = gate;
            rec_c[c] = cnt_clr;
            rec_v[c] = valid;
        end
        first_gate = -1;
        gate_len = 0;
        n_clr = 0;
        v1 = -1;
        v2 = -1;
        v_early = 0;
        for (int c = 1; c <= 3 * P; c++) begin
            if (rec_c[c]) n_clr++;
            if (rec_g[c] && first_gate < 0) first_gate = c;
            if (rec_v[c]) begin
                if (v1 < 0) v1 = c;
                else if (v2 < 0) v2 = c;
                if (c <= P) v_early++;
            end
        end
        if (first_gate > 0) begin
            for (int c = first_gate; c <= 3 * P && rec_g[c]; c++) gate_len++;
        end
        chk("seq_cnt_clr_cycles", n_clr, 3);
        chk("seq_first_gate", first_gate, 2);
        chk("seq_gate_len", gate_len, G);
        chk("seq_no_early_valid", v_early, 0);
        chk("seq_first_valid", v1, P + 1);
        chk("seq_valid_interval", v2 - v1, P);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                high = 4'($urandom_range(0, 15));
                low  = 4'($urandom_range(0, 15));
            end
            cn = ($urandom_range(0, 24) == 0);
            step();
        end
        cn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
